// File: rtl/win_screen_ctrl.sv
// End-of-game win screen: winner latch, blink/hold/exit sequencing, image-coordinate pipeline (optional WIN_COLOR_KEY_EN).
// Latency: x/y -> img_x/img_y 1 cycle, x/y -> overlay_valid 2 cycles; control outputs follow the state register.
// Backpressure: none; free-running with the VGA scan, frame_tick and start_btn are sampled every cycle.
module win_screen_ctrl #(
  parameter int          IMG_W         = 150,
  parameter int          IMG_H         = 100,
  parameter int          ORIG_X        = 245,
  parameter int          ORIG_Y        = 190,
  parameter int          BLINK_FRAMES  = 15,
  parameter int          BLINK_TOGGLES = 6,
  parameter int          HOLD_FRAMES   = 300,
  parameter int          MIN_FRAMES    = 60,
  parameter logic [11:0] KEY_CLR       = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_over,
  input  logic        winner_in,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [11:0] rom_clr,
  output logic        winner_id,
  output logic [9:0]  img_x,
  output logic [8:0]  img_y,
  output logic        overlay_valid,
  output logic        busy,
  output logic        menu_req
);

  localparam logic [9:0] X_LO       = 10'(ORIG_X);
  localparam logic [9:0] X_HI       = 10'(ORIG_X + IMG_W);
  localparam logic [8:0] Y_LO       = 9'(ORIG_Y);
  localparam logic [8:0] Y_HI       = 9'(ORIG_Y + IMG_H);
  localparam logic [8:0] BLINK_LAST = 9'(BLINK_FRAMES - 1);
  localparam logic [3:0] TOG_LAST   = 4'(BLINK_TOGGLES - 1);
  localparam logic [8:0] HOLD_MAX   = 9'(HOLD_FRAMES);
  localparam logic [8:0] MIN_CNT    = 9'(MIN_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLINK,
    ST_HOLD,
    ST_EXIT
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] frame_cnt_q, frame_cnt_d;
  logic [8:0] frame_cnt_inc;
  logic [3:0] tog_cnt_q, tog_cnt_d;
  logic       visible_q, visible_d;
  logic       winner_q, winner_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      tog_cnt_q   <= '0;
      visible_q   <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      tog_cnt_q   <= tog_cnt_d;
      visible_q   <= visible_d;
      winner_q    <= winner_d;
    end
  end

  // HOLD exit decisions look at the count including this cycle's tick.
  assign frame_cnt_inc = frame_tick ? frame_cnt_q + 9'd1 : frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    visible_d   = visible_q;
    winner_d    = winner_q;
    case (state_q)
      ST_IDLE: begin
        if (game_over) begin
          winner_d    = winner_in;
          frame_cnt_d = '0;
          tog_cnt_d   = '0;
          visible_d   = 1'b1;
          state_d     = ST_BLINK;
        end
      end
      ST_BLINK: begin
        if (frame_tick) begin
          if (frame_cnt_q == BLINK_LAST) begin
            frame_cnt_d = '0;
            if (tog_cnt_q == TOG_LAST) begin
              tog_cnt_d = '0;
              visible_d = 1'b1;
              state_d   = ST_HOLD;
            end else begin
              tog_cnt_d = tog_cnt_q + 4'd1;
              visible_d = ~visible_q;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 9'd1;
          end
        end
      end
      ST_HOLD: begin
        frame_cnt_d = frame_cnt_inc;
        if ((start_btn && (frame_cnt_inc >= MIN_CNT)) || (frame_cnt_inc >= HOLD_MAX)) begin
          state_d = ST_EXIT;
        end
      end
      ST_EXIT: begin
        frame_cnt_d = '0;
        visible_d   = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign winner_id = winner_q;
  assign busy      = (state_q != ST_IDLE);
  assign menu_req  = (state_q == ST_EXIT);

  logic in_region;
  logic show;
  logic s1_vld;
  logic s2_vld;

  assign in_region = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
  assign show      = visible_q && ((state_q == ST_BLINK) || (state_q == ST_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_x  <= '0;
      img_y  <= '0;
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      img_x  <= in_region ? (x - X_LO) : '0;
      img_y  <= in_region ? (y - Y_LO) : '0;
      s1_vld <= in_region && show;
      s2_vld <= s1_vld;
    end
  end

  // rom_clr is the ROM word for the pixel now at stage 2, so the key test is combinational here.
`ifdef WIN_COLOR_KEY_EN
  assign overlay_valid = s2_vld && (rom_clr != KEY_CLR);
`else
  logic unused_rom;
  assign unused_rom    = ^{rom_clr, KEY_CLR};
  assign overlay_valid = s2_vld;
`endif

endmodule

// File: doc/win_screen_ctrl.md
Name: win_screen_ctrl

Overview:
- Sequences the end-of-game win screen: latches the winner, and runs a blink phase, then a hold phase, then a return-to-menu request.
- Converts VGA scan coordinates into image-local coordinates for the win-image lookup block (150-pixel-wide image, address = 150*y + x, one-cycle synchronous ROM).
- Produces a pixel-aligned overlay-valid strobe for the VGA colour mux.
- Sits between the game-state logic, the VGA timing generator and the win-image lookup.

Parameters:
- IMG_W, 150, image width in pixels
- IMG_H, 100, image height in pixels
- ORIG_X, 245, screen column of the image's left edge
- ORIG_Y, 190, screen row of the image's top edge
- BLINK_FRAMES, 15, frames per blink half-period
- BLINK_TOGGLES, 6, visibility toggles in the BLINK state
- HOLD_FRAMES, 300, frames in HOLD before automatic exit
- MIN_FRAMES, 60, HOLD frames before start_btn is honoured
- KEY_CLR, 12'hF0F, transparent colour key (used only with the optional feature)

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous, active-high reset
- game_over  in  1  one-cycle pulse at end of game
- winner_in  in  1  winner id, sampled on game_over
- frame_tick  in  1  one-cycle pulse once per frame (start of vblank)
- start_btn  in  1  debounced level; exits HOLD early
- x  in  10  current VGA column
- y  in  9  current VGA row
- rom_clr  in  12  colour returned by the win-image lookup
- winner_id  out  1  latched winner, drives the lookup's winner select
- img_x  out  10  image-local column to the lookup
- img_y  out  9  image-local row to the lookup
- overlay_valid  out  1  rom_clr is to be displayed this cycle
- busy  out  1  high in any state except IDLE
- menu_req  out  1  one-cycle pulse on exit

Behaviour:
- Reset (asynchronous): state=IDLE; all counters 0; outputs winner_id, img_x, img_y, overlay_valid, menu_req all 0; busy=0.
- States: IDLE, BLINK, HOLD, EXIT.
- IDLE:
  - On game_over: latch winner_in into winner_id, clear counters, set visible=1, go to BLINK.
  - game_over in any other state is ignored; winner_id is held.
- BLINK:
  - Frame counter increments on frame_tick.
  - When it reaches BLINK_FRAMES-1 and frame_tick arrives: counter=0, visible toggles, toggle counter increments.
  - After BLINK_TOGGLES toggles: force visible=1, go to HOLD.
  - BLINK_TOGGLES is even, so the image ends visible.
- HOLD:
  - Frame counter increments on frame_tick.
  - start_btn with counter >= MIN_FRAMES, or counter reaching HOLD_FRAMES: go to EXIT.
  - start_btn below MIN_FRAMES is ignored.
- EXIT:
  - menu_req=1 for exactly one cycle, then IDLE next cycle.
  - busy=0 from IDLE onward.
- Coordinate pipeline (stage 0 → 1):
  - in_region = (x >= ORIG_X) && (x < ORIG_X+IMG_W) && (y >= ORIG_Y) && (y < ORIG_Y+IMG_H), computed combinationally from x and y.
  - Next cycle: img_x = x-ORIG_X and img_y = y-ORIG_Y if in_region, else 0.
  - Stage-1 valid = in_region && visible && state in {BLINK, HOLD}.
- Stage 2: overlay_valid = stage-1 valid delayed one cycle, aligned with the ROM's one-cycle latency.
  - Total latency from x/y to overlay_valid is 2 cycles.
- Boundaries:
  - Last in-region column is ORIG_X+IMG_W-1 = 394.
  - Column 395 gives overlay_valid=0 two cycles later.
- Mid-operation events:
  - Visibility and state changes take effect on the pipeline input; in-flight stages complete unchanged.
  - frame_tick and start_btn in the same cycle: the counter increments first, then the exit check uses the incremented value.
  - rst mid-sequence returns to IDLE immediately, with no menu_req.
- Width rules: frame counters are 9 bits, sufficient for HOLD_FRAMES ≤ 511. Subtractions are unsigned and used only when in_region.

Optional Feature:
- WIN_COLOR_KEY_EN defined: overlay_valid is additionally gated by (rom_clr != KEY_CLR) at stage 2. Key-coloured pixels fall through to the background.
- Not defined: rom_clr is unused, and every in-region visible pixel is valid.

Test Plan:
- Reset then idle scan: rst=1 for 3 cycles, then a full frame of x/y → busy=0, overlay_valid=0, menu_req=0 throughout.
- game_over with winner_in=1: winner_id=1 one cycle later. In BLINK, x=245,y=190 → img_x=0,img_y=0 next cycle, overlay_valid=1 two cycles after; x=394 valid; x=395 invalid.
- Blink timing: 15 frame_ticks → visible toggles, so a pixel at (300,200) gives overlay_valid=0. After 90 frame_ticks the state is HOLD and the pixel is valid.
- Early exit: start_btn at HOLD frame 30 → ignored. At frame 60 → menu_req pulses 1 cycle, busy falls, winner_id held.
- Timeout and interference: no button, 300 frame_ticks in HOLD → single menu_req. A second game_over during HOLD with winner_in=0 → winner_id stays 1.
- Async reset mid-BLINK: all outputs 0 without a clock edge, and no menu_req. With WIN_COLOR_KEY_EN, rom_clr=12'hF0F in region → overlay_valid=0, and 12'h123 → 1.
